// File: rtl/write_fifo_ctrl_if.sv
// Write-side bus of the async FIFO write controller.
// Groups the producer handshake, overflow control, the incoming read-domain
// Gray pointer and every status/memory output of write_fifo_ctrl.
//   slave  : the controller (consumes requests, drives strobe/address/status)
//   master : the producer / environment side
interface write_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  w_request_in;
  logic                  overflow_clear_in;
  logic [ADDR_WIDTH:0]   r_ptr_gray_in;
  logic                  w_enable_out;
  logic [ADDR_WIDTH-1:0] w_addr_out;
  logic [ADDR_WIDTH:0]   w_ptr_gray_out;
  logic                  full_out;
  logic                  almost_full_out;
  logic [ADDR_WIDTH:0]   w_level_out;
  logic                  overflow_sticky_out;

  modport slave (
    input  w_request_in, overflow_clear_in, r_ptr_gray_in,
    output w_enable_out, w_addr_out, w_ptr_gray_out, full_out,
           almost_full_out, w_level_out, overflow_sticky_out
  );

  modport master (
    output w_request_in, overflow_clear_in, r_ptr_gray_in,
    input  w_enable_out, w_addr_out, w_ptr_gray_out, full_out,
           almost_full_out, w_level_out, overflow_sticky_out
  );
endinterface

// File: rtl/write_fifo_ctrl.sv
// Write-domain controller of an asynchronous FIFO.
// Owns the (ADDR_WIDTH+1)-bit binary/Gray write pointer, synchronises the
// read-domain Gray pointer into w_clk_in and produces registered full,
// almost-full, level and sticky-overflow status plus the memory write
// strobe/address.
// Ports:
//   w_clk_in    write clock
//   w_reset_in  asynchronous, active-high reset
//   bus         write_fifo_ctrl_if.slave (request, overflow clear, read
//               Gray pointer in; write strobe, address, Gray pointer,
//               full, almost-full, level, sticky overflow out)
// ADDR_WIDTH must be >= 1; SYNC_STAGES 2..4; ALMOST_FULL_MARGIN 1..DEPTH-1.
module write_fifo_ctrl #(
  parameter int ADDR_WIDTH         = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_MARGIN = 1
) (
  input  logic              w_clk_in,
  input  logic              w_reset_in,
  write_fifo_ctrl_if.slave  bus
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Full when the Gray pointers differ in exactly the top two bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - ALMOST_FULL_MARGIN);

  logic [PW-1:0]                  w_bin, w_bin_next, w_gray_next;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  r_sync_gray, r_sync_bin, level_next;
  logic                           w_enable, full_q;

  // Acceptance is decided on the registered full flag, so a flag that
  // cleared at the last edge already permits a write this cycle.
  assign w_enable    = bus.w_request_in & ~full_q & ~w_reset_in;
  assign w_bin_next  = w_bin + {{ADDR_WIDTH{1'b0}}, w_enable};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);
  assign r_sync_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    r_sync_bin = '0;
    for (int i = 0; i < PW; i++) r_sync_bin[i] = ^(r_sync_gray >> i);
  end

  assign level_next = w_bin_next - r_sync_bin;

  // Plain flop chain; nothing else looks at r_ptr_gray_in before the last stage.
  always_ff @(posedge w_clk_in or posedge w_reset_in) begin
    if (w_reset_in) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.r_ptr_gray_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_ff @(posedge w_clk_in or posedge w_reset_in) begin
    if (w_reset_in) begin
      w_bin                   <= '0;
      bus.w_ptr_gray_out      <= '0;
      full_q                  <= 1'b0;
      bus.almost_full_out     <= 1'b0;
      bus.w_level_out         <= '0;
      bus.overflow_sticky_out <= 1'b0;
    end else begin
      w_bin               <= w_bin_next;
      bus.w_ptr_gray_out  <= w_gray_next;
      full_q              <= (w_gray_next == (r_sync_gray ^ FULL_MASK));
      bus.almost_full_out <= (level_next >= AF_THRESH);
      bus.w_level_out     <= level_next;
      // Set beats clear when both land in the same cycle.
      if (bus.w_request_in && full_q)  bus.overflow_sticky_out <= 1'b1;
      else if (bus.overflow_clear_in)  bus.overflow_sticky_out <= 1'b0;
    end
  end

  assign bus.full_out     = full_q;
  assign bus.w_enable_out = w_enable;
  assign bus.w_addr_out   = w_bin[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_write_fifo_ctrl.sv
module tb_write_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  write_fifo_ctrl_if #(.ADDR_WIDTH(3)) bus ();

  write_fifo_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .ALMOST_FULL_MARGIN(1)) dut (
    .w_clk_in  (clk),
    .w_reset_in(rst),
    .bus       (bus)
  );

  typedef struct {
    logic       req;
    logic       clr;
    logic       en;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] level;
    logic       ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, " en"},   {31'd0, bus.w_enable_out}, 0);
    chk({tag, " addr"}, {29'd0, bus.w_addr_out}, 0);
    chk({tag, " gray"}, {28'd0, bus.w_ptr_gray_out}, 0);
    chk({tag, " full"}, {31'd0, bus.full_out}, 0);
    chk({tag, " af"},   {31'd0, bus.almost_full_out}, 0);
    chk({tag, " lvl"},  {28'd0, bus.w_level_out}, 0);
    chk({tag, " ovf"},  {31'd0, bus.overflow_sticky_out}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev_gray;
    logic [3:0] wb;
    //            req   clr   en    addr  gray     full  af    level  ovf
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 3'd1, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 3'd2, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 3'd3, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 3'd4, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd5, 4'b0101, 1'b0, 1'b0, 4'd6, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 3'd6, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'd7, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    // full: requests refused, overflow set / cleared / set-wins
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};

    // Reset held with a request pending
    bus.w_request_in = 1'b1;
    bus.overflow_clear_in = 1'b0;
    bus.r_ptr_gray_in = '0;
    @(posedge clk); #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;

    // Fill, overflow and clear behaviour
    for (int i = 0; i < 14; i++) begin
      bus.w_request_in = vecs[i].req;
      bus.overflow_clear_in = vecs[i].clr;
      #1;
      chk($sformatf("v%0d en", i),   {31'd0, bus.w_enable_out}, {31'd0, vecs[i].en});
      if (vecs[i].en) chk($sformatf("v%0d addr", i), {29'd0, bus.w_addr_out}, {29'd0, vecs[i].addr});
      @(posedge clk); #1;
      chk($sformatf("v%0d gray", i), {28'd0, bus.w_ptr_gray_out}, {28'd0, vecs[i].gray});
      chk($sformatf("v%0d full", i), {31'd0, bus.full_out}, {31'd0, vecs[i].full});
      chk($sformatf("v%0d af", i),   {31'd0, bus.almost_full_out}, {31'd0, vecs[i].af});
      chk($sformatf("v%0d lvl", i),  {28'd0, bus.w_level_out}, {28'd0, vecs[i].level});
      chk($sformatf("v%0d ovf", i),  {31'd0, bus.overflow_sticky_out}, {31'd0, vecs[i].ovf});
      @(negedge clk);
    end

    // One read while full: full drops on the 3rd edge, not before
    bus.w_request_in = 1'b0;
    bus.overflow_clear_in = 1'b0;
    bus.r_ptr_gray_in = 4'b0001;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      chk($sformatf("rd e%0d full", e), {31'd0, bus.full_out}, (e == 3) ? 0 : 1);
    end
    chk("rd lvl", {28'd0, bus.w_level_out}, 7);
    @(negedge clk);
    bus.w_request_in = 1'b1;
    #1;
    chk("rd acc en", {31'd0, bus.w_enable_out}, 1);
    chk("rd acc addr", {29'd0, bus.w_addr_out}, 0);
    @(posedge clk); #1;
    chk("rd acc gray", {28'd0, bus.w_ptr_gray_out}, 4'b1101);
    chk("rd acc full", {31'd0, bus.full_out}, 1);
    chk("rd acc lvl", {28'd0, bus.w_level_out}, 8);
    @(negedge clk);

    // Streaming: read side echoes each pointer as soon as it is published,
    // so the synchroniser lag bounds occupancy at 3
    rst = 1'b1;
    bus.r_ptr_gray_in = '0;
    @(negedge clk);
    rst = 1'b0;
    wb = '0;
    prev_gray = '0;
    for (int k = 1; k <= 20; k++) begin
      bus.w_request_in = 1'b1;
      bus.r_ptr_gray_in = g(wb);
      #1;
      chk($sformatf("trk%0d en", k), {31'd0, bus.w_enable_out}, 1);
      chk($sformatf("trk%0d addr", k), {29'd0, bus.w_addr_out}, {29'd0, wb[2:0]});
      @(posedge clk); #1;
      wb = wb + 4'd1;
      chk($sformatf("trk%0d gray", k), {28'd0, bus.w_ptr_gray_out}, {28'd0, g(wb)});
      chk($sformatf("trk%0d 1bit", k), $countones(prev_gray ^ bus.w_ptr_gray_out), 1);
      chk($sformatf("trk%0d full", k), {31'd0, bus.full_out}, 0);
      chk($sformatf("trk%0d lvl", k), {28'd0, bus.w_level_out}, (k < 3) ? k : 3);
      if (k == 16) chk("trk wrap gray", {28'd0, bus.w_ptr_gray_out}, 0);
      prev_gray = bus.w_ptr_gray_out;
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a burst
    bus.w_request_in = 1'b1;
    #2;
    rst = 1'b1;
    bus.r_ptr_gray_in = '0;
    #1;
    chk_reset_vals("arst");
    @(posedge clk); #1;
    chk("arst hold gray", {28'd0, bus.w_ptr_gray_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post en", {31'd0, bus.w_enable_out}, 1);
    chk("post addr", {29'd0, bus.w_addr_out}, 0);
    @(posedge clk); #1;
    chk("post gray", {28'd0, bus.w_ptr_gray_out}, 4'b0001);
    chk("post lvl", {28'd0, bus.w_level_out}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
